id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: none; all widths come from the shared package.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 fs_to_ds_valid  in  1  fetch stage holds a valid instruction.
REQ-005 fs_to_ds_bus  in  64  {inst[63:32], pc[31:0]}.
REQ-006 ds_allowin  out  1  this stage accepts a new instruction this cycle.
REQ-007 br_bus  out  34  {br_taken_cancel[33], br_taken[32], br_target[31:0]} to fetch stage.
REQ-008 es_allowin  in  1  execute stage accepts.
REQ-009 ds_to_es_valid  out  1  decoded instruction valid to execute.
REQ-010 ds_to_es_bus  out  150  {alu_op[149:138], src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we, dest[132:128], imm, rj_value, rkd_value, pc}.
REQ-011 ws_to_rf_bus  in  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-012 es_dest, ms_dest, ws_dest  in  5 each  destination of valid, writing downstream instruction, 0 otherwise.
REQ-013 wb_ex  in  1  exception flush from writeback.

Function
REQ-014 ds_allowin SHALL equal !ds_valid || (ds_ready_go && es_allowin).
REQ-015 On fs_to_ds_valid && ds_allowin, the stage SHALL latch fs_to_ds_bus; ds_valid next = fs_to_ds_valid && !br_taken && !wb_ex.
REQ-016 Decoding SHALL cover add.w, sub.w, slt, sltu, and, or, nor, xor, slli.w, srli.w, srai.w, addi.w, lu12i.w, ld.w, st.w, jirl, b, bl, beq, bne; any other encoding SHALL decode with gr_we=0, mem_we=0, alu_op=0.
REQ-017 Immediates: si12 sign-extended; ui5 zero-extended; lu12i.w si20<<12; branch offs16/offs26 <<2, sign-extended.
REQ-018 bl and jirl SHALL set src1_is_pc=1, src2_is_imm=1, imm=4; bl dest=1, jirl dest=rd; st.w/beq/bne/b SHALL set gr_we=0.
REQ-019 Register reads: rj always; rk for 3R ops; rd for st.w, beq, bne; r0 SHALL read 0.
REQ-020 ds_ready_go SHALL be 0 while any used nonzero source register equals es_dest, ms_dest or ws_dest (no forwarding, no regfile write-through).
REQ-021 br_taken = ds_valid && ds_ready_go && !wb_ex && (b || bl || jirl || (beq && rj==rd) || (bne && rj!=rd)), combinational, same cycle.
REQ-022 br_target = pc+offs for b/bl/beq/bne; rj_value+(offs16<<2) for jirl; br_taken_cancel SHALL equal br_taken.
REQ-023 ds_to_es_valid SHALL equal ds_valid && ds_ready_go && !wb_ex.
REQ-024 wb_ex SHALL clear ds_valid at the next edge regardless of stall or incoming instruction.
REQ-025 A stalled instruction SHALL hold its bus contents; rj_value/rkd_value are re-read each cycle.
REQ-026 Regfile write SHALL occur at clk edge when rf_we && rf_waddr!=0.

Reset
REQ-027 resetn low SHALL immediately force ds_valid=0, latched inst=0, latched pc=0; hence ds_to_es_valid=0, br_taken=0, ds_allowin=1.
REQ-028 Regfile contents SHALL NOT be reset; reset deassertion SHALL take effect at the next clk edge.

Structure
REQ-029 Shared package: bus widths (64, 34, 150, 38), opcode-field constants, alu_op one-hot bit indices.
REQ-030 One sub-module regfile: 32x32, two async read ports, one sync write port.

Verification
REQ-031 Write r1=5, r2=7 via ws_to_rf_bus; issue add.w r3,r1,r2 -> ds_to_es_bus rj_value=5, rkd_value=7, dest=3, gr_we=1.
REQ-032 es_dest=4, issue addi.w r5,r4,1 -> ds_ready_go=0, ds_allowin=0 until es_dest=0, then ds_to_es_valid=1.
REQ-033 pc=0x1C000010, beq r1,r1,offs16=4 -> br_taken=1, br_target=0x1C000020; next-cycle ds_valid=0 despite fs_to_ds_valid=1.
REQ-034 pc=0x1C000000, bl offs26=0x10 -> br_target=0x1C000040, dest=1, imm=4.
REQ-035 wb_ex=1 while stalled ds_valid=1 -> ds_to_es_valid=0, br_taken=0 that cycle, ds_valid=0 next.
REQ-036 resetn low mid-stall -> ds_to_es_valid=0 and ds_allowin=1 immediately.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode-stage definitions: bus widths, opcode fields,
// ALU one-hot indices and the stage-to-stage bundle layouts.
package id_stage_pkg;

    localparam int FS_DS_W = 64;
    localparam int BR_W    = 34;
    localparam int DS_ES_W = 150;
    localparam int WS_RF_W = 38;
    localparam int ALU_W   = 12;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam logic [16:0] OP_ADD_W  = 17'h00020;
    localparam logic [16:0] OP_SUB_W  = 17'h00022;
    localparam logic [16:0] OP_SLT    = 17'h00024;
    localparam logic [16:0] OP_SLTU   = 17'h00025;
    localparam logic [16:0] OP_NOR    = 17'h00028;
    localparam logic [16:0] OP_AND    = 17'h00029;
    localparam logic [16:0] OP_OR     = 17'h0002a;
    localparam logic [16:0] OP_XOR    = 17'h0002b;
    localparam logic [16:0] OP_SLLI_W = 17'h00081;
    localparam logic [16:0] OP_SRLI_W = 17'h00089;
    localparam logic [16:0] OP_SRAI_W = 17'h00091;
    localparam logic [9:0]  OP_ADDI_W = 10'h00a;
    localparam logic [9:0]  OP_LD_W   = 10'h0a2;
    localparam logic [9:0]  OP_ST_W   = 10'h0a6;
    localparam logic [6:0]  OP_LU12I  = 7'h0a;
    localparam logic [5:0]  OP_JIRL   = 6'h13;
    localparam logic [5:0]  OP_B      = 6'h14;
    localparam logic [5:0]  OP_BL     = 6'h15;
    localparam logic [5:0]  OP_BEQ    = 6'h16;
    localparam logic [5:0]  OP_BNE    = 6'h17;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_ds_t;

    typedef struct packed {
        logic        cancel;
        logic        taken;
        logic [31:0] target;
    } br_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ws_rf_t;

    typedef struct packed {
        logic [ALU_W-1:0] alu_op;
        logic             src1_is_pc;
        logic             src2_is_imm;
        logic             res_from_mem;
        logic             gr_we;
        logic             mem_we;
        logic [4:0]       dest;
        logic [31:0]      imm;
        logic [31:0]      rj_value;
        logic [31:0]      rkd_value;
        logic [31:0]      pc;
    } ds_to_es_t;

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 general register file: two async read ports,
// one sync write port; r0 is hard-wired to zero.
module id_stage_regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem [32];

    // write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: latches fetched instruction, decodes it, reads
// registers, resolves branches and interlocks on RAW hazards.
module id_stage
    import id_stage_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               fs_to_ds_valid,
    input  logic [FS_DS_W-1:0] fs_to_ds_bus,
    output logic               ds_allowin,
    output logic [BR_W-1:0]    br_bus,
    input  logic               es_allowin,
    output logic               ds_to_es_valid,
    output logic [DS_ES_W-1:0] ds_to_es_bus,
    input  logic [WS_RF_W-1:0] ws_to_rf_bus,
    input  logic [4:0]         es_dest,
    input  logic [4:0]         ms_dest,
    input  logic [4:0]         ws_dest,
    input  logic               wb_ex
);

    fs_ds_t    fs_in;
    ws_rf_t    ws;
    br_t       br;
    ds_to_es_t es_out;

    logic        ds_valid;
    logic        ds_ready_go;
    logic        br_taken;
    logic [31:0] inst;
    logic [31:0] pc;

    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    logic [4:0]  rd, rj, rk;

    logic i_add, i_sub, i_slt, i_sltu;
    logic i_and, i_or, i_nor, i_xor;
    logic i_slli, i_srli, i_srai;
    logic i_addi, i_lu12i, i_ld, i_st;
    logic i_jirl, i_b, i_bl, i_beq, i_bne;

    logic        use_rk, use_rd;
    logic        rj_hit, rk_hit, rd_hit;
    logic [4:0]  rf_raddr2;
    logic [31:0] rj_value, rkd_value;
    logic [31:0] si12, ui5, si20, offs16, offs26;
    logic [31:0] br_target;

    assign fs_in = fs_ds_t'(fs_to_ds_bus);
    assign ws    = ws_rf_t'(ws_to_rf_bus);

    assign op17 = inst[31:15];
    assign op10 = inst[31:22];
    assign op7  = inst[31:25];
    assign op6  = inst[31:26];
    assign rd   = inst[4:0];
    assign rj   = inst[9:5];
    assign rk   = inst[14:10];

    assign i_add   = op17 == OP_ADD_W;
    assign i_sub   = op17 == OP_SUB_W;
    assign i_slt   = op17 == OP_SLT;
    assign i_sltu  = op17 == OP_SLTU;
    assign i_and   = op17 == OP_AND;
    assign i_or    = op17 == OP_OR;
    assign i_nor   = op17 == OP_NOR;
    assign i_xor   = op17 == OP_XOR;
    assign i_slli  = op17 == OP_SLLI_W;
    assign i_srli  = op17 == OP_SRLI_W;
    assign i_srai  = op17 == OP_SRAI_W;
    assign i_addi  = op10 == OP_ADDI_W;
    assign i_ld    = op10 == OP_LD_W;
    assign i_st    = op10 == OP_ST_W;
    assign i_lu12i = op7  == OP_LU12I;
    assign i_jirl  = op6  == OP_JIRL;
    assign i_b     = op6  == OP_B;
    assign i_bl    = op6  == OP_BL;
    assign i_beq   = op6  == OP_BEQ;
    assign i_bne   = op6  == OP_BNE;

    assign si12   = {{20{inst[21]}}, inst[21:10]};
    assign ui5    = {27'd0, inst[14:10]};
    assign si20   = {inst[24:5], 12'd0};
    assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign offs26 = {{4{inst[9]}}, inst[9:0],
                     inst[25:10], 2'b00};

    assign use_rk = i_add | i_sub | i_slt | i_sltu
                  | i_and | i_or  | i_nor | i_xor;
    assign use_rd = i_st | i_beq | i_bne;

    assign rf_raddr2 = use_rd ? rd : rk;

    id_stage_regfile u_rf (
        .clk    (clk),
        .raddr1 (rj),
        .rdata1 (rj_value),
        .raddr2 (rf_raddr2),
        .rdata2 (rkd_value),
        .we     (ws.we),
        .waddr  (ws.waddr),
        .wdata  (ws.wdata)
    );

    assign rj_hit = (rj != 5'd0) &&
        (rj == es_dest || rj == ms_dest || rj == ws_dest);
    assign rk_hit = (rk != 5'd0) &&
        (rk == es_dest || rk == ms_dest || rk == ws_dest);
    assign rd_hit = (rd != 5'd0) &&
        (rd == es_dest || rd == ms_dest || rd == ws_dest);

    assign ds_ready_go = !(rj_hit || (use_rk && rk_hit)
                        || (use_rd && rd_hit));

    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go && !wb_ex;

    assign br_taken = ds_to_es_valid &&
        (i_b || i_bl || i_jirl ||
         (i_beq && rj_value == rkd_value) ||
         (i_bne && rj_value != rkd_value));

    assign br_target = i_jirl ? rj_value + offs16
                     : pc + ((i_b | i_bl) ? offs26 : offs16);

    assign br.cancel = br_taken;
    assign br.taken  = br_taken;
    assign br.target = br_target;
    assign br_bus    = br;

    // decode control fields and pack the execute bundle
    always_comb begin
        es_out = '0;
        unique case (1'b1)
            i_add:  es_out.alu_op[ALU_ADD]  = 1'b1;
            i_sub:  es_out.alu_op[ALU_SUB]  = 1'b1;
            i_slt:  es_out.alu_op[ALU_SLT]  = 1'b1;
            i_sltu: es_out.alu_op[ALU_SLTU] = 1'b1;
            i_and:  es_out.alu_op[ALU_AND]  = 1'b1;
            i_or:   es_out.alu_op[ALU_OR]   = 1'b1;
            i_nor:  es_out.alu_op[ALU_NOR]  = 1'b1;
            i_xor:  es_out.alu_op[ALU_XOR]  = 1'b1;
            i_slli: es_out.alu_op[ALU_SLL]  = 1'b1;
            i_srli: es_out.alu_op[ALU_SRL]  = 1'b1;
            i_srai: es_out.alu_op[ALU_SRA]  = 1'b1;
            i_lu12i: es_out.alu_op[ALU_LUI] = 1'b1;
            i_addi, i_ld, i_st, i_jirl, i_bl:
                es_out.alu_op[ALU_ADD] = 1'b1;
            default: ;
        endcase
        es_out.gr_we = use_rk | i_slli | i_srli | i_srai
                     | i_addi | i_ld | i_lu12i | i_jirl | i_bl;
        es_out.src2_is_imm = i_slli | i_srli | i_srai | i_addi
                           | i_ld | i_st | i_lu12i
                           | i_jirl | i_bl;
        es_out.src1_is_pc   = i_jirl | i_bl;
        es_out.res_from_mem = i_ld;
        es_out.mem_we       = i_st;
        if (i_slli | i_srli | i_srai) begin
            es_out.imm = ui5;
        end else if (i_addi | i_ld | i_st) begin
            es_out.imm = si12;
        end else if (i_lu12i) begin
            es_out.imm = si20;
        end else if (i_jirl | i_bl) begin
            es_out.imm = 32'd4;
        end
        if (es_out.gr_we) begin
            es_out.dest = i_bl ? 5'd1 : rd;
        end
        es_out.rj_value  = rj_value;
        es_out.rkd_value = rkd_value;
        es_out.pc        = pc;
    end

    assign ds_to_es_bus = es_out;

    // valid bit: flush first, then accept or cancel on handoff
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (wb_ex) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid && !br_taken;
        end
    end

    // instruction/pc latch; held while the stage is stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst <= 32'd0;
            pc   <= 32'd0;
        end else if (fs_to_ds_valid && ds_allowin) begin
            inst <= fs_in.inst;
            pc   <= fs_in.pc;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus
// randomized traffic against a mnemonic-level reference model.
module tb_id_stage;
    import id_stage_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic [33:0]  br_bus;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [149:0] ds_to_es_bus;
    logic [37:0]  ws_to_rf_bus;
    logic [4:0]   es_dest, ms_dest, ws_dest;
    logic         wb_ex;

    always #5 clk = ~clk;

    id_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .ws_to_rf_bus   (ws_to_rf_bus),
        .es_dest        (es_dest),
        .ms_dest        (ms_dest),
        .ws_dest        (ws_dest),
        .wb_ex          (wb_ex)
    );

    ds_to_es_t ob;
    assign ob = ds_to_es_t'(ds_to_es_bus);

    // mnemonic table: 0 add 1 sub 2 slt 3 sltu 4 and 5 or 6 nor
    // 7 xor 8 slli 9 srli 10 srai 11 addi 12 lu12i 13 ld 14 st
    // 15 jirl 16 b 17 bl 18 beq 19 bne ; 20 = unknown
    localparam logic [31:0] TMASK [20] = '{
        32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000,
        32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000,
        32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFC00000,
        32'hFE000000, 32'hFFC00000, 32'hFFC00000, 32'hFC000000,
        32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC000000};
    localparam logic [31:0] TMATCH [20] = '{
        32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000,
        32'h00148000, 32'h00150000, 32'h00140000, 32'h00158000,
        32'h00408000, 32'h00448000, 32'h00488000, 32'h02800000,
        32'h14000000, 32'h28800000, 32'h29800000, 32'h4C000000,
        32'h50000000, 32'h54000000, 32'h58000000, 32'h5C000000};

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rfm [32];
    logic        mv;
    logic [31:0] minst, mpc;

    logic         e_allowin, e_valid, e_taken;
    logic [31:0]  e_target;
    ds_to_es_t    e_bus;

    task automatic chk(input string name,
                       input logic [149:0] act,
                       input logic [149:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int classify(input logic [31:0] i);
        for (int k = 0; k < 20; k++) begin
            if ((i & TMASK[k]) == TMATCH[k]) return k;
        end
        return 20;
    endfunction

    function automatic logic busy(input logic [4:0] r);
        return r != 5'd0 &&
            (r == es_dest || r == ms_dest || r == ws_dest);
    endfunction

    task automatic compute_exp();
        int m;
        logic [4:0] rd, rj, rk;
        logic urk, urd, stall, cond;
        logic [31:0] vj, vk;
        logic signed [31:0] o16, o26;
        m  = classify(minst);
        rd = minst[4:0];
        rj = minst[9:5];
        rk = minst[14:10];
        urk = m <= 7;
        urd = m == 14 || m == 18 || m == 19;
        vj = rfm[rj];
        vk = urd ? rfm[rd] : rfm[rk];
        stall = busy(rj) || (urk && busy(rk)) || (urd && busy(rd));
        e_bus = '0;
        e_bus.pc = mpc;
        e_bus.rj_value = vj;
        e_bus.rkd_value = vk;
        case (m)
            0: e_bus.alu_op[ALU_ADD] = 1'b1;
            1: e_bus.alu_op[ALU_SUB] = 1'b1;
            2: e_bus.alu_op[ALU_SLT] = 1'b1;
            3: e_bus.alu_op[ALU_SLTU] = 1'b1;
            4: e_bus.alu_op[ALU_AND] = 1'b1;
            5: e_bus.alu_op[ALU_OR] = 1'b1;
            6: e_bus.alu_op[ALU_NOR] = 1'b1;
            7: e_bus.alu_op[ALU_XOR] = 1'b1;
            8: e_bus.alu_op[ALU_SLL] = 1'b1;
            9: e_bus.alu_op[ALU_SRL] = 1'b1;
            10: e_bus.alu_op[ALU_SRA] = 1'b1;
            12: e_bus.alu_op[ALU_LUI] = 1'b1;
            11, 13, 14, 15, 17: e_bus.alu_op[ALU_ADD] = 1'b1;
            default: ;
        endcase
        if (m <= 13 || m == 15 || m == 17) begin
            e_bus.gr_we = 1'b1;
            e_bus.dest = (m == 17) ? 5'd1 : rd;
        end
        if (m >= 8 && m <= 10) begin
            e_bus.src2_is_imm = 1'b1;
            e_bus.imm = 32'(minst[14:10]);
        end
        if (m == 11 || m == 13 || m == 14) begin
            e_bus.src2_is_imm = 1'b1;
            e_bus.imm = 32'($signed(minst[21:10]));
        end
        if (m == 12) begin
            e_bus.src2_is_imm = 1'b1;
            e_bus.imm = {minst[24:5], 12'h000};
        end
        if (m == 15 || m == 17) begin
            e_bus.src1_is_pc = 1'b1;
            e_bus.src2_is_imm = 1'b1;
            e_bus.imm = 32'd4;
        end
        e_bus.res_from_mem = m == 13;
        e_bus.mem_we = m == 14;
        o16 = 32'($signed(minst[25:10])) * 4;
        o26 = 32'($signed({minst[9:0], minst[25:10]})) * 4;
        e_target = (m == 15) ? vj + o16
                 : mpc + ((m == 16 || m == 17) ? o26 : o16);
        cond = m == 15 || m == 16 || m == 17 ||
               (m == 18 && vj == vk) || (m == 19 && vj != vk);
        e_valid = mv && !stall && !wb_ex;
        e_taken = e_valid && cond;
        e_allowin = !mv || (!stall && es_allowin);
    endtask

    task automatic model_check();
        compute_exp();
        chk("ds_allowin", 150'(ds_allowin), 150'(e_allowin));
        chk("ds_to_es_valid", 150'(ds_to_es_valid), 150'(e_valid));
        chk("br_taken", 150'(br_bus[32]), 150'(e_taken));
        chk("br_cancel", 150'(br_bus[33]), 150'(e_taken));
        if (e_taken) chk("br_target", 150'(br_bus[31:0]), 150'(e_target));
        if (e_valid) chk("ds_to_es_bus", ds_to_es_bus, e_bus);
    endtask

    task automatic model_update();
        if (ws_to_rf_bus[37] && ws_to_rf_bus[36:32] != 5'd0)
            rfm[ws_to_rf_bus[36:32]] = ws_to_rf_bus[31:0];
        if (!resetn) begin
            mv = 1'b0;
            minst = '0;
            mpc = '0;
        end else begin
            if (fs_to_ds_valid && e_allowin)
                {minst, mpc} = fs_to_ds_bus;
            if (wb_ex) mv = 1'b0;
            else if (e_allowin) mv = fs_to_ds_valid && !e_taken;
        end
    endtask

    task automatic cyc();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        fs_to_ds_valid = 1'b0;
        es_allowin = 1'b1;
        es_dest = '0;
        ms_dest = '0;
        ws_dest = '0;
        wb_ex = 1'b0;
        ws_to_rf_bus = '0;
    endtask

    function automatic logic [4:0] fld();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_inst();
        int k;
        logic [31:0] i;
        k = $urandom_range(0, 20);
        if (k == 20) return $urandom;
        i = TMATCH[k] | ($urandom & ~TMASK[k]);
        i[14:10] = fld();
        i[9:5] = fld();
        i[4:0] = fld();
        return i;
    endfunction

    function automatic logic [4:0] rdest();
        if ($urandom_range(0, 1) == 0) return 5'd0;
        return 5'($urandom_range(1, 7));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rfm[i] = '0;
        mv = 1'b0;
        minst = '0;
        mpc = '0;
        resetn = 1'b0;
        fs_to_ds_bus = '0;
        idle();
        @(negedge clk);
        #1;
        chk("rst_allowin", 150'(ds_allowin), 150'(1'b1));
        chk("rst_es_valid", 150'(ds_to_es_valid), 150'(1'b0));
        chk("rst_br_taken", 150'(br_bus[32]), 150'(1'b0));
        cyc();
        resetn = 1'b1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            ws_to_rf_bus = {1'b1, 5'(i),
                (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : $urandom};
            cyc();
        end
        idle();

        // add.w r3,r1,r2
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h00100823, 32'h1C000000};
        cyc();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("add_valid", 150'(ds_to_es_valid), 150'(1'b1));
        chk("add_rj", 150'(ob.rj_value), 150'(32'd5));
        chk("add_rkd", 150'(ob.rkd_value), 150'(32'd7));
        chk("add_dest", 150'(ob.dest), 150'(5'd3));
        chk("add_gr_we", 150'(ob.gr_we), 150'(1'b1));
        cyc();

        // addi.w r5,r4,1 stalled by es_dest=4
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h02800485, 32'h1C000004};
        es_dest = 5'd4;
        cyc();
        fs_to_ds_bus = {32'h00100823, 32'h1C000008};
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_allowin", 150'(ds_allowin), 150'(1'b0));
            chk("stall_es_valid", 150'(ds_to_es_valid), 150'(1'b0));
            cyc();
        end
        es_dest = 5'd0;
        fs_to_ds_valid = 1'b0;
        #1;
        chk("unstall_valid", 150'(ds_to_es_valid), 150'(1'b1));
        chk("unstall_imm", 150'(ob.imm), 150'(32'd1));
        cyc();

        // beq r1,r1,+16 at 0x1C000010
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h58001021, 32'h1C000010};
        cyc();
        fs_to_ds_bus = {32'h00100823, 32'h1C000014};
        #1;
        chk("beq_taken", 150'(br_bus[32]), 150'(1'b1));
        chk("beq_cancel", 150'(br_bus[33]), 150'(1'b1));
        chk("beq_target", 150'(br_bus[31:0]), 150'(32'h1C000020));
        cyc();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("beq_cancelled", 150'(ds_to_es_valid), 150'(1'b0));
        chk("beq_empty", 150'(ds_allowin), 150'(1'b1));
        cyc();

        // bl offs26=0x10 at 0x1C000000
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h54004000, 32'h1C000000};
        cyc();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("bl_taken", 150'(br_bus[32]), 150'(1'b1));
        chk("bl_target", 150'(br_bus[31:0]), 150'(32'h1C000040));
        chk("bl_dest", 150'(ob.dest), 150'(5'd1));
        chk("bl_imm", 150'(ob.imm), 150'(32'd4));
        cyc();

        // wb_ex on a stalled beq
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h58001021, 32'h1C000030};
        es_dest = 5'd1;
        cyc();
        fs_to_ds_valid = 1'b0;
        cyc();
        wb_ex = 1'b1;
        es_dest = 5'd0;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h00100823, 32'h1C000034};
        #1;
        chk("ex_es_valid", 150'(ds_to_es_valid), 150'(1'b0));
        chk("ex_br_taken", 150'(br_bus[32]), 150'(1'b0));
        cyc();
        idle();
        #1;
        chk("ex_flushed", 150'(ds_to_es_valid), 150'(1'b0));
        chk("ex_allowin", 150'(ds_allowin), 150'(1'b1));
        cyc();

        // reset mid-stall
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h00100823, 32'h1C000040};
        es_dest = 5'd2;
        cyc();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("pre_rst_stall", 150'(ds_allowin), 150'(1'b0));
        cyc();
        resetn = 1'b0;
        mv = 1'b0;
        minst = '0;
        mpc = '0;
        #1;
        chk("mid_rst_es_valid", 150'(ds_to_es_valid), 150'(1'b0));
        chk("mid_rst_allowin", 150'(ds_allowin), 150'(1'b1));
        cyc();
        resetn = 1'b1;
        es_dest = 5'd0;
        cyc();
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h00100823, 32'h1C000050};
        cyc();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("rf_kept_r1", 150'(ob.rj_value), 150'(32'd5));
        chk("rf_kept_r2", 150'(ob.rkd_value), 150'(32'd7));
        cyc();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            fs_to_ds_valid = $urandom_range(0, 3) != 0;
            fs_to_ds_bus = {rand_inst(), $urandom};
            es_allowin = $urandom_range(0, 3) != 0;
            es_dest = rdest();
            ms_dest = rdest();
            ws_dest = rdest();
            wb_ex = $urandom_range(0, 15) == 0;
            ws_to_rf_bus = {1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 1)
                    ? 32'($urandom_range(0, 3)) : $urandom};
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
